// File: rtl/id_ex_operandos.sv
// ID/EX pipeline register and EX-stage operand selector for the MIPS32 core.
// It captures the decoded instruction, forwards rs/rt from EX/MEM and MEM/WB,
// selects the ALU operands, and detects load-use hazards, stalling IF/ID while
// a bubble enters EX.
// Optional build macro: ID_EX_CONTADOR_BOLHAS_EN adds the cnt_bolhas output,
// a saturating count of the bubbles loaded by flush or load-use stall.
module id_ex_operandos #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_codigo_controle,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_dado,
    input  logic [DATA_W-1:0] id_rt_dado,
    input  logic [DATA_W-1:0] id_imediato,
    input  logic [4:0]        id_shamt,
    input  logic              id_usa_rs,
    input  logic              id_usa_rt,
    input  logic              id_usa_imediato,
    input  logic              id_usa_shamt,
    input  logic              id_escreve_reg,
    input  logic              id_le_mem,
    input  logic              id_escreve_mem,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic              exmem_escreve_reg,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_resultado,
    input  logic              memwb_escreve_reg,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_dado,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [3:0]        codigo_controle,
    output logic [DATA_W-1:0] operando_A,
    output logic [DATA_W-1:0] operando_B,
    output logic [DATA_W-1:0] ex_dado_store,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_escreve_reg,
    output logic              ex_le_mem,
    output logic              ex_escreve_mem
`ifdef ID_EX_CONTADOR_BOLHAS_EN
    ,
    output logic [31:0]       cnt_bolhas
`endif
);

    // A bubble is simply this record cleared to zero: invalid, no controls,
    // every index 0, so its operands come from register 0 and never forward.
    typedef struct packed {
        logic              valid;
        logic [3:0]        codigo;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rs_dado;
        logic [DATA_W-1:0] rt_dado;
        logic [DATA_W-1:0] imediato;
        logic [4:0]        shamt;
        logic              usa_imediato;
        logic              usa_shamt;
        logic              escreve_reg;
        logic              le_mem;
        logic              escreve_mem;
    } campos_t;

    campos_t campos_q, campos_d, entrada;
    logic    flush_pendente_q, flush_pendente_d;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // Register 0 is hard-wired, so it never takes a forwarded value; EX/MEM
    // is younger than MEM/WB and therefore wins when both match.
    function automatic logic [DATA_W-1:0] encaminha(
        input logic [REG_W-1:0]  idx,
        input logic [DATA_W-1:0] dado_rf,
        input logic              em_wr,
        input logic [REG_W-1:0]  em_rd,
        input logic [DATA_W-1:0] em_val,
        input logic              wb_wr,
        input logic [REG_W-1:0]  wb_rd,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] r;
        r = dado_rf;
        if (idx != '0) begin
            if (em_wr && em_rd == idx)      r = em_val;
            else if (wb_wr && wb_rd == idx) r = wb_val;
        end
        return r;
    endfunction

    assign entrada = '{
        valid:        id_valid,
        codigo:       id_codigo_controle,
        rs:           id_rs,
        rt:           id_rt,
        rd:           id_rd,
        rs_dado:      id_rs_dado,
        rt_dado:      id_rt_dado,
        imediato:     id_imediato,
        shamt:        id_shamt,
        usa_imediato: id_usa_imediato,
        usa_shamt:    id_usa_shamt,
        escreve_reg:  id_escreve_reg,
        le_mem:       id_le_mem,
        escreve_mem:  id_escreve_mem
    };

    // Load-use hazard: the load in EX cannot supply ID's source in time; a
    // frozen EX already holds the front end, so the stall is masked then.
    always_comb begin
        id_stall = 1'b0;
        if (!ex_hold && campos_q.valid && campos_q.le_mem && campos_q.rd != '0 && id_valid) begin
            id_stall = (id_usa_rs && id_rs == campos_q.rd) ||
                       (id_usa_rt && id_rt == campos_q.rd);
        end
    end

    // Next-state selection: hold (remembering any flush), then flush or
    // deferred flush, then load-use bubble, otherwise accept the decoded word.
    always_comb begin
        campos_d         = campos_q;
        flush_pendente_d = flush_pendente_q;
        if (ex_hold) begin
            flush_pendente_d = flush_pendente_q | flush;
        end else if (flush || flush_pendente_q) begin
            campos_d         = '0;
            flush_pendente_d = 1'b0;
        end else if (id_stall) begin
            campos_d = '0;
        end else begin
            campos_d = entrada;
        end
    end

    // ID/EX register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            campos_q         <= '0;
            flush_pendente_q <= 1'b0;
        end else begin
            campos_q         <= campos_d;
            flush_pendente_q <= flush_pendente_d;
        end
    end

    // Forwarded sources and ALU operand selection, combinational in EX.
    always_comb begin
        rs_fwd = encaminha(campos_q.rs, campos_q.rs_dado, exmem_escreve_reg, exmem_rd,
                           exmem_resultado, memwb_escreve_reg, memwb_rd, memwb_dado);
        rt_fwd = encaminha(campos_q.rt, campos_q.rt_dado, exmem_escreve_reg, exmem_rd,
                           exmem_resultado, memwb_escreve_reg, memwb_rd, memwb_dado);
        if (campos_q.usa_shamt) begin
            operando_A = rt_fwd;
            operando_B = {{(DATA_W-5){1'b0}}, campos_q.shamt};
        end else begin
            operando_A = rs_fwd;
            operando_B = campos_q.usa_imediato ? campos_q.imediato : rt_fwd;
        end
    end

    assign ex_dado_store   = rt_fwd;
    assign ex_valid        = campos_q.valid;
    assign codigo_controle = campos_q.codigo;
    assign ex_rd           = campos_q.rd;
    assign ex_escreve_reg  = campos_q.valid & campos_q.escreve_reg;
    assign ex_le_mem       = campos_q.valid & campos_q.le_mem;
    assign ex_escreve_mem  = campos_q.valid & campos_q.escreve_mem;

`ifdef ID_EX_CONTADOR_BOLHAS_EN
    logic [31:0] cnt_bolhas_q;
    logic        bolha_carregada;

    assign bolha_carregada = ~ex_hold & (flush | flush_pendente_q | id_stall);

    // Saturating count of bubbles inserted by flush or load-use stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_bolhas_q <= '0;
        end else if (bolha_carregada && cnt_bolhas_q != 32'hFFFF_FFFF) begin
            cnt_bolhas_q <= cnt_bolhas_q + 32'd1;
        end
    end

    assign cnt_bolhas = cnt_bolhas_q;
`endif

endmodule

// File: tb/tb_id_ex_operandos.sv
// Testbench for id_ex_operandos: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the ID/EX stage.
module tb_id_ex_operandos;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_codigo_controle;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_rs_dado, id_rt_dado, id_imediato;
    logic        id_usa_rs, id_usa_rt, id_usa_imediato, id_usa_shamt;
    logic        id_escreve_reg, id_le_mem, id_escreve_mem;
    logic        ex_hold, flush;
    logic        exmem_escreve_reg, memwb_escreve_reg;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_resultado, memwb_dado;
    logic        id_stall, ex_valid;
    logic [3:0]  codigo_controle;
    logic [31:0] operando_A, operando_B, ex_dado_store;
    logic [4:0]  ex_rd;
    logic        ex_escreve_reg, ex_le_mem, ex_escreve_mem;
`ifdef ID_EX_CONTADOR_BOLHAS_EN
    logic [31:0] cnt_bolhas;
`endif

    id_ex_operandos dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_codigo_controle(id_codigo_controle),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_dado(id_rs_dado), .id_rt_dado(id_rt_dado),
        .id_imediato(id_imediato), .id_shamt(id_shamt),
        .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt),
        .id_usa_imediato(id_usa_imediato), .id_usa_shamt(id_usa_shamt),
        .id_escreve_reg(id_escreve_reg), .id_le_mem(id_le_mem),
        .id_escreve_mem(id_escreve_mem), .ex_hold(ex_hold), .flush(flush),
        .exmem_escreve_reg(exmem_escreve_reg), .exmem_rd(exmem_rd),
        .exmem_resultado(exmem_resultado),
        .memwb_escreve_reg(memwb_escreve_reg), .memwb_rd(memwb_rd),
        .memwb_dado(memwb_dado), .id_stall(id_stall), .ex_valid(ex_valid),
        .codigo_controle(codigo_controle), .operando_A(operando_A),
        .operando_B(operando_B), .ex_dado_store(ex_dado_store),
        .ex_rd(ex_rd), .ex_escreve_reg(ex_escreve_reg),
        .ex_le_mem(ex_le_mem), .ex_escreve_mem(ex_escreve_mem)
`ifdef ID_EX_CONTADOR_BOLHAS_EN
        , .cnt_bolhas(cnt_bolhas)
`endif
    );

    always #5 clk = ~clk;

    // Model of the instruction sitting in EX.
    typedef struct {
        bit          valid;
        logic [3:0]  cod;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] rsd, rtd, imm;
        bit          ui, us, wr, lm, wm;
    } instr_t;

    instr_t      mEx, mNext;
    bit          mPend, mPendNext;
    logic [31:0] mBolhas, mBolhasNext;
    int          total = 0;
    int          bad   = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 0, cod: 4'h0, rs: 5'd0, rt: 5'd0, rd: 5'd0, sh: 5'd0,
              rsd: 32'd0, rtd: 32'd0, imm: 32'd0, ui: 0, us: 0, wr: 0, lm: 0, wm: 0};
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Value of architectural register idx as seen by EX this cycle.
    function automatic logic [31:0] regValue(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (exmem_escreve_reg && exmem_rd == idx) return exmem_resultado;
        if (memwb_escreve_reg && memwb_rd == idx) return memwb_dado;
        return rf;
    endfunction

    function automatic bit expStall();
        if (ex_hold || !mEx.valid || !mEx.lm || mEx.rd == 5'd0 || !id_valid) return 0;
        return (id_usa_rs && id_rs == mEx.rd) || (id_usa_rt && id_rt == mEx.rd);
    endfunction

    task automatic checkAll();
        logic [31:0] a, b, st;
        st = regValue(mEx.rt, mEx.rtd);
        a  = mEx.us ? st : regValue(mEx.rs, mEx.rsd);
        b  = mEx.us ? {27'd0, mEx.sh} : (mEx.ui ? mEx.imm : st);
        checkOutput("stall", {31'd0, id_stall}, {31'd0, expStall()});
        checkOutput("valid", {31'd0, ex_valid}, {31'd0, mEx.valid});
        checkOutput("codigo", {28'd0, codigo_controle}, {28'd0, mEx.cod});
        checkOutput("opA", operando_A, a);
        checkOutput("opB", operando_B, b);
        checkOutput("store", ex_dado_store, st);
        checkOutput("rd", {27'd0, ex_rd}, {27'd0, mEx.rd});
        checkOutput("wr", {31'd0, ex_escreve_reg}, {31'd0, mEx.valid & mEx.wr});
        checkOutput("lm", {31'd0, ex_le_mem}, {31'd0, mEx.valid & mEx.lm});
        checkOutput("wm", {31'd0, ex_escreve_mem}, {31'd0, mEx.valid & mEx.wm});
`ifdef ID_EX_CONTADOR_BOLHAS_EN
        checkOutput("cnt", cnt_bolhas, mBolhas);
`endif
    endtask

    task automatic atNegedge();
        @(negedge clk);
        checkAll();
    endtask

    // Model update for one rising edge, then inputs may change at +1.
    task automatic advance();
        mNext = mEx; mPendNext = mPend; mBolhasNext = mBolhas;
        if (reset) begin
            mNext = bubble(); mPendNext = 0; mBolhasNext = 32'd0;
        end else if (ex_hold) begin
            mPendNext = mPend | flush;
        end else if (flush || mPend || expStall()) begin
            mNext = bubble(); mPendNext = 0;
            if (mBolhas != 32'hFFFF_FFFF) mBolhasNext = mBolhas + 32'd1;
        end else begin
            mNext = '{valid: id_valid, cod: id_codigo_controle, rs: id_rs, rt: id_rt,
                      rd: id_rd, sh: id_shamt, rsd: id_rs_dado, rtd: id_rt_dado,
                      imm: id_imediato, ui: id_usa_imediato, us: id_usa_shamt,
                      wr: id_escreve_reg, lm: id_le_mem, wm: id_escreve_mem};
        end
        @(posedge clk);
        mEx = mNext; mPend = mPendNext; mBolhas = mBolhasNext;
        #1;
    endtask

    task automatic clearInputs();
        id_valid = 0; id_codigo_controle = 4'h0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        id_shamt = 5'd0; id_rs_dado = 32'd0; id_rt_dado = 32'd0; id_imediato = 32'd0;
        id_usa_rs = 0; id_usa_rt = 0; id_usa_imediato = 0; id_usa_shamt = 0;
        id_escreve_reg = 0; id_le_mem = 0; id_escreve_mem = 0;
        ex_hold = 0; flush = 0;
        exmem_escreve_reg = 0; exmem_rd = 5'd0; exmem_resultado = 32'd0;
        memwb_escreve_reg = 0; memwb_rd = 5'd0; memwb_dado = 32'd0;
    endtask

    // add $10, $8, $9 with register-file values 0x10 and 0x20.
    task automatic driveAdd();
        id_valid = 1; id_codigo_controle = 4'h0; id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd10;
        id_rs_dado = 32'h10; id_rt_dado = 32'h20; id_usa_rs = 1; id_usa_rt = 1;
        id_usa_imediato = 0; id_usa_shamt = 0; id_escreve_reg = 1; id_le_mem = 0;
        id_escreve_mem = 0; id_shamt = 5'd0; id_imediato = 32'd0;
    endtask

    task automatic applyStimulus();
        id_valid           = 1'($urandom_range(0, 3) != 0);
        id_codigo_controle = 4'($urandom);
        id_rs              = 5'($urandom_range(0, 3));
        id_rt              = 5'($urandom_range(0, 3));
        id_rd              = 5'($urandom_range(0, 3));
        id_shamt           = 5'($urandom);
        id_rs_dado         = $urandom;
        id_rt_dado         = $urandom;
        id_imediato        = $urandom;
        id_usa_rs          = 1'($urandom_range(0, 1));
        id_usa_rt          = 1'($urandom_range(0, 1));
        id_usa_imediato    = 1'($urandom_range(0, 1));
        id_usa_shamt       = 1'($urandom_range(0, 3) == 0);
        id_escreve_reg     = 1'($urandom_range(0, 1));
        id_le_mem          = 1'($urandom_range(0, 2) == 0);
        id_escreve_mem     = 1'($urandom_range(0, 3) == 0);
        ex_hold            = 1'($urandom_range(0, 4) == 0);
        flush              = 1'($urandom_range(0, 7) == 0);
        exmem_escreve_reg  = 1'($urandom_range(0, 1));
        exmem_rd           = 5'($urandom_range(0, 3));
        exmem_resultado    = $urandom;
        memwb_escreve_reg  = 1'($urandom_range(0, 1));
        memwb_rd           = 5'($urandom_range(0, 3));
        memwb_dado         = $urandom;
        reset              = 1'($urandom_range(0, 39) == 0);
    endtask

    initial begin
        clearInputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        mEx = bubble(); mPend = 0; mBolhas = 32'd0;

        // Reset state.
        atNegedge();
        checkOutput("rst_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_codigo", {28'd0, codigo_controle}, 32'd0);
        advance();
        reset = 0;

        // Plain add, no forwarding.
        driveAdd();
        atNegedge();
        advance();
        atNegedge();
        checkOutput("add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("add_A", operando_A, 32'h10);
        checkOutput("add_B", operando_B, 32'h20);

        // Forwarding priority and register 0.
        exmem_escreve_reg = 1; exmem_rd = 5'd8; exmem_resultado = 32'hAA;
        memwb_escreve_reg = 1; memwb_rd = 5'd8; memwb_dado = 32'hBB;
        #1; checkAll();
        checkOutput("fwd_exmem", operando_A, 32'hAA);
        exmem_escreve_reg = 0;
        #1; checkAll();
        checkOutput("fwd_memwb", operando_A, 32'hBB);
        id_rs = 5'd0; id_rs_dado = 32'h55;
        advance();
        exmem_escreve_reg = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        atNegedge();
        checkOutput("fwd_r0", operando_A, 32'h55);
        exmem_escreve_reg = 0; memwb_escreve_reg = 0;

        // Load-use: lw $8 in EX, add reading $8 in ID.
        driveAdd();
        id_rs = 5'd1; id_rd = 5'd8; id_le_mem = 1; id_usa_imediato = 1; id_imediato = 32'h4;
        advance();
        driveAdd();
        atNegedge();
        checkOutput("lu_stall", {31'd0, id_stall}, 32'd1);
        advance();
        atNegedge();
        checkOutput("lu_stall_off", {31'd0, id_stall}, 32'd0);
        checkOutput("lu_bubble", {31'd0, ex_valid}, 32'd0);
        advance();
        atNegedge();
        checkOutput("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("lu_add_A", operando_A, 32'h10);

        // sll: A from rt, B from shamt.
        driveAdd();
        id_rt = 5'd3; id_rt_dado = 32'h3; id_shamt = 5'd4; id_usa_shamt = 1; id_usa_rs = 0;
        advance();
        atNegedge();
        checkOutput("sll_A", operando_A, 32'h3);
        checkOutput("sll_B", operando_B, 32'h4);

        // Hold for two cycles with flush in the first.
        driveAdd();
        ex_hold = 1; flush = 1;
        advance();
        flush = 0;
        atNegedge();
        checkOutput("hold1_B", operando_B, 32'h4);
        advance();
        ex_hold = 0;
        atNegedge();
        checkOutput("hold2_B", operando_B, 32'h4);
        advance();
        atNegedge();
        checkOutput("hold_flush_bubble", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_CONTADOR_BOLHAS_EN
        checkOutput("cnt_two", cnt_bolhas, 32'd2);
`endif
        advance();
        atNegedge();
        checkOutput("after_flush_valid", {31'd0, ex_valid}, 32'd1);
        advance();

        // Randomized traffic with hazards, holds, flushes and resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus();
            atNegedge();
            advance();
        end

        // Final reset clears everything.
        clearInputs();
        reset = 1;
        advance();
        reset = 0;
        atNegedge();
        checkOutput("end_rst_valid", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_CONTADOR_BOLHAS_EN
        checkOutput("end_rst_cnt", cnt_bolhas, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
